// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and the buffered write-entry type for the
//            register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter_if
// Purpose  : Primary/secondary write, hazard query and register-file port
//            bundle for wb_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic                       pri_we_i;
    logic [REG_ADDR_W-1:0]      pri_addr_i;
    logic [REG_DATA_W-1:0]      pri_data_i;
    logic                       sec_valid_i;
    logic                       sec_ready_o;
    logic [REG_ADDR_W-1:0]      sec_addr_i;
    logic [REG_DATA_W-1:0]      sec_data_i;
    logic [REG_ADDR_W-1:0]      query_addr_i;
    logic                       pending_o;
    logic                       stall_req_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic [REG_ADDR_W-1:0]      writeaddr_o;
    logic [REG_DATA_W-1:0]      writedata_o;
    logic                       regwrite_o;

    modport slave (
        input  pri_we_i, pri_addr_i, pri_data_i,
        input  sec_valid_i, sec_addr_i, sec_data_i, query_addr_i,
        output sec_ready_o, pending_o, stall_req_o, count_o,
        output writeaddr_o, writedata_o, regwrite_o
    );

    modport master (
        output pri_we_i, pri_addr_i, pri_data_i,
        output sec_valid_i, sec_addr_i, sec_data_i, query_addr_i,
        input  sec_ready_o, pending_o, stall_req_o, count_o,
        input  writeaddr_o, writedata_o, regwrite_o
    );

endinterface : wb_write_arbiter_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : In-order FIFO of wb_entry_t with per-slot valid/addr exposure
//            so the parent can search buffered destinations.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire                                 clk_i,
    input  wire                                 rst_i,
    input  wire                                 i_push,
    input  wb_entry_t                           i_entry,
    input  wire                                 i_pop,
    output wb_entry_t                           o_head,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic                                o_full,
    output logic                                o_empty,
    output logic [DEPTH-1:0]                    o_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    o_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: slot validity is derived from pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            localparam logic [PW-1:0] c_idx = PW'(i);
            logic [PW-1:0] w_off;
            assign w_off      = c_idx - r_rd_ptr;
            assign o_valid[i] = ({1'b0, w_off} < r_count);
            assign o_addr[i]  = r_mem[i].addr;
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Merges primary writeback and buffered secondary writes onto the
//            single register-file write port. Define WBARB_BYPASS_EN to let a
//            secondary write skip an empty FIFO on an idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  wire                 clk_i,
    input  wire                 rst_i,
    wb_write_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_entry_t                          w_head;
    wb_entry_t                          w_sec_entry;
    logic                               w_full;
    logic                               w_empty;
    logic [DEPTH-1:0]                   w_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   w_addr;
    logic [DEPTH-1:0]                   w_match;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_bypass;
    logic                               w_store;
    logic [SW-1:0]                      r_starve;
    logic                               r_stall;
    logic [REG_ADDR_W-1:0]              r_waddr;
    logic [REG_DATA_W-1:0]              r_wdata;
    logic                               r_we;

    assign w_sec_entry     = '{addr: bus.sec_addr_i, data: bus.sec_data_i};
    assign bus.sec_ready_o = !w_full;
    assign w_push          = bus.sec_valid_i && !w_full;
    assign w_pop           = !bus.pri_we_i && !w_empty;

`ifdef WBARB_BYPASS_EN
    // Zero-address pushes are dropped, so they never take the bypass.
    assign w_bypass = w_push && w_empty && !bus.pri_we_i && (bus.sec_addr_i != '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_store = w_push && (bus.sec_addr_i != '0) && !w_bypass;

    wb_fifo #(
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_store),
        .i_entry (w_sec_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (bus.count_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (w_valid),
        .o_addr  (w_addr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (bus.pri_we_i) begin
            r_we <= (bus.pri_addr_i != '0);
            if (bus.pri_addr_i != '0) begin
                r_waddr <= bus.pri_addr_i;
                r_wdata <= bus.pri_data_i;
            end
        end else if (w_pop) begin
            r_waddr <= w_head.addr;
            r_wdata <= w_head.data;
            r_we    <= 1'b1;
        end else if (w_bypass) begin
            r_waddr <= bus.sec_addr_i;
            r_wdata <= bus.sec_data_i;
            r_we    <= 1'b1;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Stall is registered from the counter, so it trails the counter by a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_empty || w_pop)
                r_starve <= '0;
            else if (bus.pri_we_i && (r_starve < SW'(STARVE_MAX)))
                r_starve <= r_starve + 1'b1;
            r_stall <= (r_starve >= SW'(STARVE_MAX));
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            assign w_match[i] = w_valid[i] && (w_addr[i] == bus.query_addr_i);
        end
    endgenerate

    assign bus.pending_o   = (bus.query_addr_i != '0) &&
                             ((|w_match) || (r_we && (r_waddr == bus.query_addr_i)));
    assign bus.stall_req_o = r_stall;
    assign bus.writeaddr_o = r_waddr;
    assign bus.writedata_o = r_wdata;
    assign bus.regwrite_o  = r_we;

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Directed self-checking bench for wb_write_arbiter (DEPTH=4,
//            STARVE_MAX=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    wb_write_arbiter_if #(.DEPTH(4)) bus ();

    wb_write_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_total          = 0;
        n_pass           = 0;
        rst              = 1'b1;
        bus.pri_we_i     = 1'b0;
        bus.pri_addr_i   = '0;
        bus.pri_data_i   = '0;
        bus.sec_valid_i  = 1'b0;
        bus.sec_addr_i   = '0;
        bus.sec_data_i   = '0;
        bus.query_addr_i = 5'd3;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset then idle
        check("rst_regwrite", bus.regwrite_o, 0);
        check("rst_waddr", bus.writeaddr_o, 0);
        check("rst_wdata", bus.writedata_o, 0);
        check("rst_ready", bus.sec_ready_o, 1);
        check("rst_count", bus.count_o, 0);
        check("rst_stall", bus.stall_req_o, 0);
        check("rst_pending", bus.pending_o, 0);

        // Primary only
        bus.pri_we_i   = 1'b1;
        bus.pri_addr_i = 5'd5;
        bus.pri_data_i = 32'hDEADBEEF;
        tick();
        check("pri_regwrite", bus.regwrite_o, 1);
        check("pri_waddr", bus.writeaddr_o, 5);
        check("pri_wdata", bus.writedata_o, 32'hDEADBEEF);
        bus.query_addr_i = 5'd5;
        #1;
        check("pri_pending_inflight", bus.pending_o, 1);
        bus.pri_addr_i = 5'd0;
        bus.pri_data_i = 32'h1234;
        tick();
        check("pri_zero_regwrite", bus.regwrite_o, 0);
        check("pri_zero_pending", bus.pending_o, 0);

        // Fill the FIFO under primary pressure
        bus.pri_addr_i  = 5'd10;
        bus.pri_data_i  = 32'hAA;
        bus.sec_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.sec_addr_i = 5'(i);
            bus.sec_data_i = 32'h100 + 32'(i);
            tick();
        end
        bus.sec_valid_i = 1'b0;
        check("fill_count", bus.count_o, 4);
        check("fill_ready", bus.sec_ready_o, 0);
        bus.query_addr_i = 5'd3;
        #1;
        check("fill_pending_q3", bus.pending_o, 1);
        bus.query_addr_i = 5'd7;
        #1;
        check("fill_pending_q7", bus.pending_o, 0);

        // Release and drain in order
        bus.pri_we_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_regwrite", bus.regwrite_o, 1);
            check("drain_waddr", bus.writeaddr_o, 64'(i));
            check("drain_wdata", bus.writedata_o, 64'(32'h100 + 32'(i)));
            check("drain_count", bus.count_o, 64'(4 - i));
            check("drain_ready", bus.sec_ready_o, 1);
        end
        tick();
        check("drain_idle_regwrite", bus.regwrite_o, 0);
        check("drain_stall", bus.stall_req_o, 0);

        // Starvation: one buffered entry held off by continuous primary writes
        bus.pri_we_i    = 1'b1;
        bus.pri_addr_i  = 5'd11;
        bus.pri_data_i  = 32'hBB;
        bus.sec_valid_i = 1'b1;
        bus.sec_addr_i  = 5'd6;
        bus.sec_data_i  = 32'h66;
        tick();
        bus.sec_valid_i = 1'b0;
        check("starve_count", bus.count_o, 1);
        for (int i = 0; i < 8; i++) tick();
        check("starve_stall_early", bus.stall_req_o, 0);
        tick();
        check("starve_stall_high", bus.stall_req_o, 1);
        bus.pri_we_i = 1'b0;
        tick();
        check("starve_pop_regwrite", bus.regwrite_o, 1);
        check("starve_pop_waddr", bus.writeaddr_o, 6);
        check("starve_pop_count", bus.count_o, 0);
        tick();
        check("starve_stall_low", bus.stall_req_o, 0);

        // Secondary write into an empty FIFO on an idle cycle
        bus.sec_valid_i = 1'b1;
        bus.sec_addr_i  = 5'd9;
        bus.sec_data_i  = 32'h99;
        tick();
        bus.sec_valid_i = 1'b0;
`ifdef WBARB_BYPASS_EN
        check("byp_regwrite_n1", bus.regwrite_o, 1);
        check("byp_waddr_n1", bus.writeaddr_o, 9);
        check("byp_count_n1", bus.count_o, 0);
`else
        check("sec_regwrite_n1", bus.regwrite_o, 0);
        check("sec_count_n1", bus.count_o, 1);
        tick();
        check("sec_regwrite_n2", bus.regwrite_o, 1);
        check("sec_waddr_n2", bus.writeaddr_o, 9);
        check("sec_wdata_n2", bus.writedata_o, 32'h99);
        check("sec_count_n2", bus.count_o, 0);
`endif

        // Zero-address push is accepted and dropped
        bus.pri_we_i    = 1'b1;
        bus.pri_addr_i  = 5'd12;
        bus.sec_valid_i = 1'b1;
        bus.sec_addr_i  = 5'd0;
        tick();
        check("zero_push_count", bus.count_o, 0);

        // Reset mid-drain with three buffered entries
        for (int i = 0; i < 3; i++) begin
            bus.sec_addr_i = 5'(13 + i);
            bus.sec_data_i = 32'h200 + 32'(i);
            tick();
        end
        bus.sec_valid_i = 1'b0;
        check("mid_count_before", bus.count_o, 3);
        bus.pri_we_i = 1'b0;
        rst          = 1'b1;
        #1;
        check("mid_count_rst", bus.count_o, 0);
        check("mid_regwrite_rst", bus.regwrite_o, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_regwrite_after1", bus.regwrite_o, 0);
        tick();
        check("mid_regwrite_after2", bus.regwrite_o, 0);
        check("mid_count_after", bus.count_o, 0);
        bus.query_addr_i = 5'd14;
        #1;
        check("mid_pending_after", bus.pending_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Merges register-file writes from the pipeline writeback stage and from a multi-cycle secondary unit (load-miss or mul/div return) onto the register file's single write port. Primary writes always win; secondary writes are buffered in a small FIFO and drained into idle write-port cycles. The block sits directly upstream of the register file, driving its write address, write data and write enable. It also gives the decode/hazard logic a pending-write query and a starvation stall request.

## Interface
- DEPTH, 4: secondary FIFO entries; power of two, ≥2
- STARVE_MAX, 8: consecutive blocked cycles before `stall_req_o` asserts
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- pri_we_i  in  1  primary write request; no backpressure
- pri_addr_i  in  5  primary destination register
- pri_data_i  in  32  primary write data
- sec_valid_i  in  1  secondary write offered
- sec_ready_o  out  1  FIFO can accept; equals !full
- sec_addr_i  in  5  secondary destination register
- sec_data_i  in  32  secondary write data
- query_addr_i  in  5  register address probed by hazard logic
- pending_o  out  1  a write to `query_addr_i` is buffered or in flight; combinational
- stall_req_o  out  1  request a pipeline bubble so the FIFO can drain
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy
- writeaddr_o  out  5  to register-file write address
- writedata_o  out  32  to register-file write data
- regwrite_o  out  1  to register-file write enable

## Operation
- Reset values: every output and output register is 0. The FIFO is empty, so `sec_ready_o` is 1. The starve counter is 0. Asserting reset mid-operation discards all buffered writes.
- Secondary push: a push occurs when `sec_valid_i && sec_ready_o`. A push with `sec_addr_i==0` is accepted and dropped; it is not stored.
- Primary path: when `pri_we_i` is high and `pri_addr_i!=0`, the output registers load the primary address and data with `regwrite_o=1`. When `pri_addr_i==0`, `regwrite_o` goes to 0 and the write is discarded.
- Pop: when `pri_we_i` is low and the FIFO is non-empty, the FIFO head loads the output registers and `regwrite_o` goes to 1.
- Idle: otherwise `regwrite_o` goes to 0.
- Simultaneous push and pop in one cycle is legal. The count is unchanged and `sec_ready_o` stays as it was.
- Order: the FIFO is strictly in order. The arbiter does not reorder writes between the two sources. Decode uses `pending_o` to enforce ordering.
- `pending_o` is 1 when `query_addr_i!=0` and either condition holds:
  - the address matches any valid FIFO entry;
  - the address matches `writeaddr_o` while `regwrite_o=1`.
- Starve counter:
  - increments, saturating, each cycle that the FIFO is non-empty and `pri_we_i=1`;
  - clears on a pop or when the FIFO is empty;
  - `stall_req_o` = counter ≥ STARVE_MAX, driven from a register.

## Timing
- Primary: a request in cycle N appears on `regwrite_o` at edge N+1, and the register file writes it at edge N+2.
- Secondary, without bypass: push at N → earliest pop at N+1 → output at N+2.
- Full: with DEPTH entries stored, `sec_ready_o=0` from the following cycle. A pop in that cycle raises ready the next cycle.
- Pointers wrap modulo DEPTH. `count_o` distinguishes full from empty.
- `stall_req_o` rises the cycle after the counter reaches STARVE_MAX. It falls the cycle after the first pop.

## Configuration
- `WBARB_BYPASS_EN` defined: when a push occurs, the FIFO is empty and `pri_we_i=0`, the entry goes straight to the output registers. Output is at N+1, the entry is not stored and `count_o` stays 0.
- Macro undefined: every secondary write passes through the FIFO, with minimum latency N+2.

## Structure
- Package `wb_pkg` holds:
  - `REG_ADDR_W=5` and `REG_DATA_W=32`;
  - typedef `wb_entry_t` {addr, data}.
- Sub-module `wb_fifo`: a synchronous FIFO of `wb_entry_t` with registered pointers and count. It exposes per-entry valid/addr vectors for the `pending_o` compare.
- The arbiter, starve counter and output registers live in `wb_write_arbiter`.

## Test plan
- Reset then idle: all outputs are 0, `sec_ready_o=1`, `count_o=0`.
- Primary only: `pri_we_i=1`, addr 5, data 0xDEADBEEF → `regwrite_o=1`, `writeaddr_o=5`, `writedata_o=0xDEADBEEF` one edge later. Addr 0 → `regwrite_o=0`.
- Fill: hold `pri_we_i=1` and push 4 secondary writes to addrs 1–4:
  - `count_o=4` and `sec_ready_o=0`;
  - `pending_o=1` for query 3 and 0 for query 7;
  - after release, writes emerge in order 1,2,3,4 on consecutive cycles.
- Starvation: with STARVE_MAX=8, keep 1 entry buffered and `pri_we_i=1` → `stall_req_o` rises after 8 blocked cycles. Drop `pri_we_i` → a pop occurs and `stall_req_o` falls the next cycle.
- Bypass: empty FIFO, `pri_we_i=0`, push addr 9:
  - with `WBARB_BYPASS_EN`, output appears at N+1 and `count_o` stays 0;
  - without the macro, output appears at N+2 and `count_o` is 1 at N+1.
- Reset mid-drain: with 3 entries buffered, assert `rst_i` → `count_o=0`, `regwrite_o=0`, and no stale write appears after release.
